// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: headings, control states and button bundle.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    localparam int unsigned NUM_BTN = 5;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic start;
    } btn_t;

    // Up/down and left/right differ only in bit 0.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

endpackage

// File: rtl/snake_debounce.sv
// One raw button: 2-flop synchroniser, stability counter, accepted level and rising-edge press.
module snake_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic VGA_clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // Counter only runs while the synced input disagrees with the accepted level.
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_2;
                press <= sync_2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Button conditioning, heading selection, run/halt sequencing and move pacing for the snake game.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned MOVE_DIV        = 2500000,
    parameter dir_t        DIR_INIT        = DIR_RIGHT
) (
    input  logic       VGA_clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       start,
    input  logic       game_over,
    output logic [1:0] dir,
    output logic       move_tick,
    output logic       start_pulse,
    output logic       running
);

    localparam int unsigned TICK_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MOVE_DIV - 1);

    logic [NUM_BTN-1:0] raw_vec;
    logic [NUM_BTN-1:0] level_vec;
    logic [NUM_BTN-1:0] press_vec;
    btn_t               btn;

    state_t            state, state_d;
    dir_t              dir_q, dir_d;
    dir_t              pending, pending_d;
    logic [TICK_W-1:0] tick_cnt, tick_cnt_d;
    logic              move_tick_d;
    logic              start_pulse_d;
    logic              running_d;
    logic              turn_req;
    dir_t              turn_dir;

    assign raw_vec = {up, down, left, right, start};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        snake_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .VGA_clk(VGA_clk),
            .reset  (reset),
            .raw    (raw_vec[i]),
            .level  (level_vec[i]),
            .press  (press_vec[i])
        );
    end

    // A press is only honoured while its accepted level is still asserted.
    assign btn = btn_t'(press_vec & level_vec);
    assign dir = dir_q;

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            state       <= IDLE;
            dir_q       <= DIR_INIT;
            pending     <= DIR_INIT;
            tick_cnt    <= '0;
            move_tick   <= 1'b0;
            start_pulse <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= state_d;
            dir_q       <= dir_d;
            pending     <= pending_d;
            tick_cnt    <= tick_cnt_d;
            move_tick   <= move_tick_d;
            start_pulse <= start_pulse_d;
            running     <= running_d;
        end
    end

    always_comb begin
        state_d       = state;
        dir_d         = dir_q;
        pending_d     = pending;
        tick_cnt_d    = tick_cnt;
        move_tick_d   = 1'b0;
        start_pulse_d = 1'b0;
        turn_req      = 1'b1;
        turn_dir      = DIR_UP;

        // Highest-priority press only; a rejected reversal does not fall through.
        if (btn.up) begin
            turn_dir = DIR_UP;
        end else if (btn.down) begin
            turn_dir = DIR_DOWN;
        end else if (btn.left) begin
            turn_dir = DIR_LEFT;
        end else if (btn.right) begin
            turn_dir = DIR_RIGHT;
        end else begin
            turn_req = 1'b0;
        end

        case (state)
            IDLE, HALT: begin
                if (btn.start) begin
                    state_d       = RUN;
                    start_pulse_d = 1'b1;
                    dir_d         = DIR_INIT;
                    pending_d     = DIR_INIT;
                    tick_cnt_d    = '0;
                end
            end
            RUN: begin
                if (game_over) begin
                    state_d = HALT;
                end else begin
                    if (turn_req && (turn_dir != opposite(dir_q))) begin
                        pending_d = turn_dir;
                    end
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_d  = '0;
                        move_tick_d = 1'b1;
                        dir_d       = pending_d;
                    end else begin
                        tick_cnt_d = tick_cnt + TICK_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        running_d = (state_d == RUN);
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Scoreboard bench for snake_dir_ctrl: expected tick/start events are queued, a monitor checks them as they appear.
module tb_snake_dir_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned MOV = 8;
    localparam int K_TICK  = 1;
    localparam int K_PULSE = 2;

    logic       VGA_clk   = 1'b0;
    logic       reset     = 1'b1;
    logic       up        = 1'b0;
    logic       down      = 1'b0;
    logic       left      = 1'b0;
    logic       right     = 1'b0;
    logic       start     = 1'b0;
    logic       game_over = 1'b0;
    logic [1:0] dir;
    logic       move_tick;
    logic       start_pulse;
    logic       running;

    typedef struct {
        int         kind;
        int         cycle;
        logic [1:0] dir;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    snake_dir_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .MOVE_DIV       (MOV)
    ) dut (
        .VGA_clk    (VGA_clk),
        .reset      (reset),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .start      (start),
        .game_over  (game_over),
        .dir        (dir),
        .move_tick  (move_tick),
        .start_pulse(start_pulse),
        .running    (running)
    );

    always #5 VGA_clk = ~VGA_clk;

    always @(posedge VGA_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int kind, input int cycle, input logic [1:0] d);
        exp_t e;
        e.kind  = kind;
        e.cycle = cycle;
        e.dir   = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge VGA_clk);
            #1;
        end
    endtask

    // Monitor: every tick or start pulse must match the next queued expectation.
    always @(negedge VGA_clk) begin
        if (move_tick || start_pulse) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event at cycle %0d: tick=%0d pulse=%0d, expected no event",
                         cyc, move_tick, start_pulse);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", int'({start_pulse, move_tick}), mon_e.kind);
                check("event_cycle", cyc, mon_e.cycle);
                check("event_dir", int'(dir), int'(mon_e.dir));
                check("event_running", int'(running), 1);
            end
        end
    end

    initial begin : stim
        int s;
        int s2;

        // Reset state
        wait_cyc(3);
        check("reset_dir", int'(dir), 3);
        check("reset_running", int'(running), 0);
        check("reset_tick", int'(move_tick), 0);
        check("reset_pulse", int'(start_pulse), 0);
        reset = 1'b0;

        // 1: start held 10 clocks
        s = 12;
        wait_cyc(5);
        start = 1'b1;
        push(K_PULSE, s, 2'b11);
        push(K_TICK, s + 8, 2'b11);
        push(K_TICK, s + 16, 2'b11);
        wait_cyc(s + 1);
        check("running_after_start", int'(running), 1);
        wait_cyc(15);
        start = 1'b0;

        // 2: bouncing up button
        for (int i = 0; i < 20; i++) begin
            wait_cyc(s + 1 + i);
            up = ((i / 2) % 2) == 0;
        end
        wait_cyc(s + 21);
        up = 1'b0;

        // 3: reversal rejected, then a legal turn committed on the next tick
        push(K_TICK, s + 24, 2'b11);
        push(K_TICK, s + 32, 2'b11);
        push(K_TICK, s + 40, 2'b11);
        wait_cyc(s + 22);
        left = 1'b1;
        wait_cyc(s + 30);
        left = 1'b0;
        wait_cyc(s + 34);
        up = 1'b1;
        push(K_TICK, s + 48, 2'b00);
        wait_cyc(s + 42);
        up = 1'b0;
        wait_cyc(s + 44);
        check("dir_before_tick", int'(dir), 3);
        wait_cyc(s + 50);
        right = 1'b1;
        push(K_TICK, s + 56, 2'b00);
        push(K_TICK, s + 64, 2'b11);
        wait_cyc(s + 58);
        right = 1'b0;

        // 4: up then down close together; down lands after up is committed
        wait_cyc(s + 64);
        up = 1'b1;
        push(K_TICK, s + 72, 2'b00);
        push(K_TICK, s + 80, 2'b00);
        wait_cyc(s + 66);
        down = 1'b1;
        wait_cyc(s + 72);
        up = 1'b0;
        wait_cyc(s + 74);
        down  = 1'b0;
        right = 1'b1;
        push(K_TICK, s + 88, 2'b11);
        wait_cyc(s + 82);
        right = 1'b0;

        // 5: simultaneous up+left, then game_over on the terminal count, then restart
        wait_cyc(s + 90);
        up   = 1'b1;
        left = 1'b1;
        push(K_TICK, s + 96, 2'b11);
        push(K_TICK, s + 104, 2'b00);
        wait_cyc(s + 98);
        up   = 1'b0;
        left = 1'b0;
        wait_cyc(s + 111);
        game_over = 1'b1;
        wait_cyc(s + 112);
        check("halt_running", int'(running), 0);
        check("halt_no_tick", int'(move_tick), 0);
        wait_cyc(s + 115);
        start = 1'b1;
        s2 = s + 122;
        push(K_PULSE, s2, 2'b11);
        wait_cyc(s + 120);
        check("halt_holds", int'(running), 0);
        wait_cyc(s2);
        game_over = 1'b0;
        up        = 1'b1;
        push(K_TICK, s2 + 8, 2'b00);
        wait_cyc(s2 + 1);
        start = 1'b0;
        wait_cyc(s2 + 8);
        up = 1'b0;

        // 6: reset mid-run at count 5
        wait_cyc(s2 + 13);
        check("dir_before_reset", int'(dir), 0);
        reset = 1'b1;
        wait_cyc(s2 + 14);
        check("midreset_dir", int'(dir), 3);
        check("midreset_running", int'(running), 0);
        check("midreset_tick", int'(move_tick), 0);
        check("midreset_pulse", int'(start_pulse), 0);
        reset = 1'b0;
        wait_cyc(s2 + 30);
        check("idle_after_reset", int'(running), 0);
        check("pending_events", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
